// File: rtl/keypad_pkg.sv
// Shared constants, types and small helpers for the keypad scanner.
package keypad_pkg;

  localparam int unsigned KP_ROWS   = 5;
  localparam int unsigned KP_COLS   = 4;
  localparam int unsigned KP_CODE_W = 5;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} kp_state_t;
  typedef enum logic [1:0] {NONE, SINGLE, MULTI} kp_result_t;

  // Index of the lowest pressed column (0 when none pressed).
  function automatic logic [1:0] lowest_col(input logic [KP_COLS-1:0] pressed);
    lowest_col = 2'd0;
    for (int i = KP_COLS - 1; i >= 0; i--) begin
      if (pressed[i]) lowest_col = 2'(i);
    end
  endfunction

  function automatic logic [2:0] count_keys(input logic [KP_COLS-1:0] pressed);
    count_keys = 3'd0;
    for (int i = 0; i < KP_COLS; i++) begin
      count_keys = count_keys + 3'(pressed[i]);
    end
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchroniser for asynchronous sense lines; resets to the idle (high) level.
module keypad_sync #(
  parameter int unsigned Width = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] meta;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 5x4 matrix keypad scanner with debounce and multi-key rejection.
// Optional auto-repeat is built when KEYPAD_REPEAT_EN is defined.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned REPEAT_DELAY   = 40,
  parameter int unsigned REPEAT_PERIOD  = 10
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [KP_COLS-1:0]   col_n,
  output logic [KP_ROWS-1:0]   row_n,
  output logic                 newkey,
  output logic [KP_CODE_W-1:0] keycode
);

  localparam int unsigned DwellW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DbW    = $clog2(DEBOUNCE_SCANS + 1);

  logic [KP_COLS-1:0]   col_s;
  logic [DwellW-1:0]    dwell;
  logic [2:0]           row;
  logic [1:0]           acc_cnt;
  logic [KP_CODE_W-1:0] acc_code;
  logic                 acc_cand;
  kp_state_t            state;
  logic [KP_CODE_W-1:0] cand;
  logic [DbW-1:0]       cnt;

  logic                 sample, scan_end;
  logic [KP_COLS-1:0]   pressed;
  logic [2:0]           acc_sum;
  logic [1:0]           cnt_nxt;
  logic [KP_CODE_W-1:0] code_nxt;
  logic                 cand_nxt;
  kp_result_t           result;

  keypad_sync #(
    .Width(KP_COLS)
  ) u_col_sync (
    .clock  (clock),
    .reset_n(reset_n),
    .d      (col_n),
    .q      (col_s)
  );

  // Accumulator values including the row being sampled this cycle.
  always_comb begin
    sample   = (dwell == DwellW'(SCAN_DIV - 1));
    scan_end = sample && (row == 3'(KP_ROWS - 1));
    pressed  = ~col_s;
    acc_sum  = {1'b0, acc_cnt} + count_keys(pressed);
    cnt_nxt  = (acc_sum >= 3'd2) ? 2'd2 : acc_sum[1:0];
    code_nxt = acc_code;
    if (acc_cnt == 2'd0 && pressed != '0) code_nxt = {row, lowest_col(pressed)};
    cand_nxt = acc_cand | ((row == cand[4:2]) && pressed[cand[1:0]]);
    result   = (cnt_nxt == 2'd0) ? NONE : (cnt_nxt == 2'd1) ? SINGLE : MULTI;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dwell    <= '0;
      row      <= '0;
      row_n    <= 5'b11110;
      acc_cnt  <= '0;
      acc_code <= '0;
      acc_cand <= 1'b0;
    end else if (sample) begin
      dwell <= '0;
      row   <= scan_end ? 3'd0 : row + 3'd1;
      row_n <= {row_n[KP_ROWS-2:0], row_n[KP_ROWS-1]};
      if (scan_end) begin
        acc_cnt  <= '0;
        acc_code <= '0;
        acc_cand <= 1'b0;
      end else begin
        acc_cnt  <= cnt_nxt;
        acc_code <= code_nxt;
        acc_cand <= cand_nxt;
      end
    end else begin
      dwell <= dwell + 1'b1;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RepW   = $clog2(RepMax + 1);
  logic [RepW-1:0] rep_cnt;
  logic            rep_first;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cand    <= '0;
      cnt     <= '0;
      newkey  <= 1'b0;
      keycode <= '0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= '0;
      rep_first <= 1'b1;
`endif
    end else begin
      newkey <= 1'b0;
      if (scan_end) begin
        unique case (state)
          IDLE: begin
            if (result == SINGLE) begin
              cand <= code_nxt;
              if (DEBOUNCE_SCANS == 1) begin
                state   <= HELD;
                newkey  <= 1'b1;
                keycode <= code_nxt;
`ifdef KEYPAD_REPEAT_EN
                rep_cnt   <= '0;
                rep_first <= 1'b1;
`endif
              end else begin
                state <= DEBOUNCE;
                cnt   <= DbW'(1);
              end
            end
          end
          DEBOUNCE: begin
            if (result == SINGLE && code_nxt == cand) begin
              if (cnt + 1'b1 == DbW'(DEBOUNCE_SCANS)) begin
                state   <= HELD;
                cnt     <= '0;
                newkey  <= 1'b1;
                keycode <= cand;
`ifdef KEYPAD_REPEAT_EN
                rep_cnt   <= '0;
                rep_first <= 1'b1;
`endif
              end else begin
                cnt <= cnt + 1'b1;
              end
            end else begin
              state <= IDLE;
              cnt   <= '0;
            end
          end
          HELD: begin
            if (cand_nxt) begin
`ifdef KEYPAD_REPEAT_EN
              if (rep_cnt + 1'b1 == (rep_first ? RepW'(REPEAT_DELAY) : RepW'(REPEAT_PERIOD))) begin
                newkey    <= 1'b1;
                rep_cnt   <= '0;
                rep_first <= 1'b0;
              end else begin
                rep_cnt <= rep_cnt + 1'b1;
              end
`endif
            end else begin
              // A single quiet scan already completes the release when DEBOUNCE_SCANS is 1.
              state <= (result == NONE && DEBOUNCE_SCANS == 1) ? IDLE : RELEASE;
              cnt   <= (result == NONE && DEBOUNCE_SCANS != 1) ? DbW'(1) : '0;
`ifdef KEYPAD_REPEAT_EN
              rep_cnt <= '0;
`endif
            end
          end
          RELEASE: begin
            if (result == NONE) begin
              if (cnt + 1'b1 == DbW'(DEBOUNCE_SCANS)) begin
                state <= IDLE;
                cnt   <= '0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end else begin
              cnt <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench: matrix model drives col_n; a scan-level model predicts key events.
module tb_keypad_scanner;

  localparam int unsigned SD = 4;
  localparam int unsigned DB = 2;
  localparam int unsigned RD = 4;
  localparam int unsigned RP = 2;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  col_n;
  logic [4:0]  row_n;
  logic        newkey;
  logic [4:0]  keycode;
  logic [19:0] keys = '0;

  int passed = 0;
  int total  = 0;

  // Scan-level reference state.
  int m_held  = -1;
  int m_rkey  = 0;
  int m_rlen  = 0;
  int m_quiet = 0;
  int m_age   = 0;
  int m_code  = 0;
  bit m_rel   = 1'b0;

  always #5 clock = ~clock;

  keypad_scanner #(
    .SCAN_DIV      (SD),
    .DEBOUNCE_SCANS(DB),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .col_n  (col_n),
    .row_n  (row_n),
    .newkey (newkey),
    .keycode(keycode)
  );

  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row_n[r] && keys[r*4+c]) col_n[c] = 1'b0;
      end
    end
  end

  function automatic logic [19:0] key(input int i);
    key = 20'd1 << i;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_held = -1; m_rkey = 0; m_rlen = 0; m_quiet = 0; m_age = 0; m_code = 0; m_rel = 1'b0;
  endtask

  // One scan's worth of pressed keys in, expected event out.
  function automatic bit model_step(input logic [19:0] eff);
    int n;
    int low;
    bit emit;
    n    = $countones(eff);
    low  = -1;
    emit = 1'b0;
    for (int i = 19; i >= 0; i--) if (eff[i]) low = i;
    if (m_held < 0) begin
      if (n == 1 && m_rlen > 0 && low == m_rkey) m_rlen++;
      else if (n == 1 && m_rlen == 0) begin
        m_rkey = low;
        m_rlen = 1;
      end else m_rlen = 0;
      if (m_rlen == DB) begin
        emit = 1'b1; m_held = m_rkey; m_code = m_rkey; m_rel = 1'b0; m_age = 0; m_rlen = 0;
      end
    end else if (!m_rel) begin
      if (eff[m_held]) begin
        m_age++;
`ifdef KEYPAD_REPEAT_EN
        if (m_age >= RD && (m_age - RD) % RP == 0) emit = 1'b1;
`endif
      end else begin
        m_rel   = 1'b1;
        m_quiet = (n == 0) ? 1 : 0;
      end
    end else begin
      m_quiet = (n == 0) ? m_quiet + 1 : 0;
    end
    if (m_rel && m_quiet >= DB) begin
      m_held = -1;
      m_rel  = 1'b0;
    end
    return emit;
  endfunction

  // rs[r] is the key set held while row r is driven; starts at a scan boundary.
  task automatic run_scan(input logic [4:0][19:0] rs, input string tag);
    int          pulses;
    logic [19:0] eff;
    logic [4:0]  exp_row;
    bit          exp_pulse;
    pulses = 0;
    eff    = '0;
    for (int r = 0; r < 5; r++) begin
      exp_row = ~(5'b00001 << r);
      chk({tag, "/row_n"}, {27'd0, row_n}, {27'd0, exp_row});
      keys = rs[r];
      eff  = eff | (rs[r] & (20'hF << (4 * r)));
      repeat (SD) begin
        @(posedge clock);
        #1;
        if (newkey) pulses++;
      end
    end
    exp_pulse = model_step(eff);
    chk({tag, "/pulses"}, pulses, {31'd0, exp_pulse});
    chk({tag, "/keycode"}, {27'd0, keycode}, m_code);
  endtask

  task automatic hold(input logic [19:0] s, input int n, input string tag);
    for (int i = 0; i < n; i++) run_scan({5{s}}, tag);
  endtask

  initial begin
    logic [4:0][19:0] rs;
    int sel;
    int tgt;

    repeat (3) @(posedge clock);
    #1;
    chk("reset/row_n", {27'd0, row_n}, 32'd30);
    chk("reset/newkey", {31'd0, newkey}, 32'd0);
    chk("reset/keycode", {27'd0, keycode}, 32'd0);
    @(negedge clock) reset_n = 1'b1;

    hold(key(9), 8, "clean9");
    hold('0, 3, "clean9_rel");

    for (int r = 0; r < 5; r++) rs[r] = (r % 2 == 0) ? key(19) : '0;
    run_scan(rs, "bounce_a");
    for (int r = 0; r < 5; r++) rs[r] = (r % 2 == 1) ? key(19) : '0;
    run_scan(rs, "bounce_b");
    hold(key(19), 5, "bounce_hold");
    hold('0, 3, "bounce_rel");

    hold(key(0) | key(5), 10, "multi");
    hold('0, 1, "multi_rel");
    hold(key(0), 3, "k0");
    hold(key(0) | key(5), 4, "k0_k5");
    hold(key(5), 4, "k5_left");
    hold('0, 2, "k5_rel");
    hold(key(5), 3, "k5");
    hold('0, 3, "k5_rel2");

    hold(key(3), 3, "k3");
    hold('0, 1, "k3_gap1");
    hold(key(3), 3, "k3_repress");
    hold('0, 3, "k3_gap3");
    hold(key(3), 3, "k3_again");
    hold('0, 3, "k3_rel");

    hold(key(12), 1, "rst_pre");
    keys = key(12);
    repeat (7) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid/row_n", {27'd0, row_n}, 32'd30);
    chk("rst_mid/newkey", {31'd0, newkey}, 32'd0);
    chk("rst_mid/keycode", {27'd0, keycode}, 32'd0);
    keys = '0;
    model_reset();
    repeat (3) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    hold('0, 2, "rst_post");

    hold(key(7), 14, "repeat7");
    hold('0, 3, "repeat7_rel");

    tgt = $urandom_range(0, 19);
    for (int i = 0; i < 80; i++) begin
      sel = $urandom_range(0, 9);
      if ($urandom_range(0, 3) == 0) tgt = $urandom_range(0, 19);
      if (sel < 3) rs = '0;
      else if (sel < 8) rs = {5{key(tgt)}};
      else if (sel == 8) rs = {5{key(tgt) | key($urandom_range(0, 19))}};
      else for (int r = 0; r < 5; r++) rs[r] = key(tgt) & {20{$urandom_range(0, 1) == 1}};
      run_scan(rs, "rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
